// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the single-outstanding imem
// request handshake and the IF/ID pipeline register.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   stall               - hazard stall, freezes PC and IF/ID
//   branch_taken/target - ID-stage redirect (target bits [1:0] dropped)
//   halt                - stop fetching, sticky until reset
//   imem_req_*          - request handshake (valid/ready/addr)
//   imem_rsp_*          - response (valid/data), latency >= 1
//   if_id_*             - IF/ID register (instr, pc_plus4, valid)
//   halted              - fetch stopped with nothing outstanding
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] skid_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic        kill_q;
    logic        hlatch_q;
    logic        valid_q;
    logic        halted_q;

    logic        redir;
    logic        req_fire;
    logic [31:0] tgt;
    logic [31:0] req_pc4;

    // A branch frozen in ID by a stall re-evaluates later.
    assign redir    = branch_taken & ~stall;
    assign tgt      = branch_target & 32'hFFFF_FFFC;
    assign req_pc4  = req_pc_q + 32'd4;

    assign imem_req_valid = (state_q == S_REQ) & ~hlatch_q
                          & ~halt & ~redir;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign imem_addr      = pc_q;

    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pcp4_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            skid_q   <= NOP_INSTR;
            kill_q   <= 1'b0;
            hlatch_q <= 1'b0;
            instr_q  <= NOP_INSTR;
            pcp4_q   <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            hlatch_q <= hlatch_q | halt;
            // IF/ID takes a bubble unless a delivery below overrides it.
            if (!stall) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (redir) begin
                        pc_q <= tgt;
                    end else if (req_fire) begin
                        req_pc_q <= pc_q;
                        kill_q   <= 1'b0;
                        state_q  <= S_WAIT;
                    end else if (halt | hlatch_q) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        pc_q <= tgt;
                        if (imem_rsp_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            // Wrong-path response still in flight.
                            kill_q <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!stall) begin
                            instr_q <= imem_rsp_data;
                            pcp4_q  <= req_pc4;
                            valid_q <= 1'b1;
                            pc_q    <= req_pc4;
                            state_q <= S_REQ;
                        end else begin
                            skid_q  <= imem_rsp_data;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (redir) begin
                            pc_q <= tgt;
                        end else begin
                            instr_q <= skid_q;
                            pcp4_q  <= req_pc4;
                            valid_q <= 1'b1;
                            pc_q    <= req_pc4;
                        end
                        state_q <= S_REQ;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule
